// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  // One cycle counter serves every timed state, so it is sized for the longest interval.
  function automatic int cnt_width(input int rst_cycles, input int stable_cycles,
                                   input int timeout_cycles);
    int m;
    m = rst_cycles;
    if (stable_cycles > m) m = stable_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  function automatic int retry_width(input int max_retry);
    return (max_retry <= 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/pll_lock_ch.sv
// Single-channel PLL supervisor: lock synchronizer, sequencing FSM and,
// with LOCK_LOSS_CNT_EN defined, a saturating lock-loss counter.
module pll_lock_ch
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES     = 27,
  parameter int STABLE_CYCLES  = 2700,
  parameter int TIMEOUT_CYCLES = 27000,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lock_i,
  input  logic             en_i,
  input  logic             clear_i,
  output logic             pll_rst_o,
  output logic             ready_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] loss_cnt_o
);

  localparam int CW = cnt_width(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam int RW = retry_width(MAX_RETRY);
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY - 1);

  logic          r_lock_meta;
  logic          r_lock_s;
  pll_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_retry;
  logic          r_pll_rst;
  logic          r_ready;
  logic          r_fault;

  // lock_i is asynchronous to clk; nothing else may look at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= lock_i;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RESET;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_pll_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_pll_rst <= (r_state == ST_RESET) || (r_state == ST_FAULT);
      r_ready   <= (r_state == ST_LOCKED);
      r_fault   <= (r_state == ST_FAULT);
      if (!en_i) begin
        r_state <= ST_RESET;
        r_cnt   <= '0;
        r_retry <= '0;
      end else begin
        case (r_state)
          ST_RESET: begin
            if (r_cnt == RST_LAST) begin
              r_state <= ST_WAIT_LOCK;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (r_lock_s) begin
              r_state <= ST_STABLE;
              r_cnt   <= '0;
            end else if (r_cnt == TIMEOUT_LAST) begin
              r_retry <= r_retry + 1'b1;
              r_state <= (r_retry == RETRY_LAST) ? ST_FAULT : ST_RESET;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_STABLE: begin
            if (!r_lock_s) begin
              r_state <= ST_WAIT_LOCK;
              r_cnt   <= '0;
            end else if (r_cnt == STABLE_LAST) begin
              r_state <= ST_LOCKED;
              r_cnt   <= '0;
              r_retry <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!r_lock_s) begin
              r_state <= ST_RESET;
              r_cnt   <= '0;
            end
          end
          ST_FAULT: begin
            if (clear_i) begin
              r_state <= ST_RESET;
              r_cnt   <= '0;
              r_retry <= '0;
            end
          end
          default: begin
            r_state <= ST_RESET;
            r_cnt   <= '0;
            r_retry <= '0;
          end
        endcase
      end
    end
  end

  assign pll_rst_o = r_pll_rst;
  assign ready_o   = r_ready;
  assign fault_o   = r_fault;

`ifdef LOCK_LOSS_CNT_EN
  logic             w_loss_evt;
  logic [CNT_W-1:0] r_loss_cnt;

  // Only a genuine drop out of LOCKED counts; disabling the channel does not.
  assign w_loss_evt = en_i && (r_state == ST_LOCKED) && !r_lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && (r_loss_cnt != {CNT_W{1'b1}})) begin
      r_loss_cnt <= r_loss_cnt + 1'b1;
    end
  end

  assign loss_cnt_o = r_loss_cnt;
`else
  assign loss_cnt_o = '0;
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// Multi-channel rPLL lock supervisor with global all_ready release.
// Define LOCK_LOSS_CNT_EN to enable the per-channel lock-loss counters.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int RST_CYCLES     = 27,
  parameter int STABLE_CYCLES  = 2700,
  parameter int TIMEOUT_CYCLES = 27000,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       lock_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       clear_i,
  output logic [NUM_CH-1:0]       pll_rst_o,
  output logic [NUM_CH-1:0]       ready_o,
  output logic [NUM_CH-1:0]       fault_o,
  output logic                    all_ready_o,
  output logic [NUM_CH*CNT_W-1:0] loss_cnt_o
);

  logic r_all_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pll_lock_ch #(
      .RST_CYCLES    (RST_CYCLES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .MAX_RETRY     (MAX_RETRY),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .lock_i    (lock_i[g]),
      .en_i      (en_i[g]),
      .clear_i   (clear_i[g]),
      .pll_rst_o (pll_rst_o[g]),
      .ready_o   (ready_o[g]),
      .fault_o   (fault_o[g]),
      .loss_cnt_o(loss_cnt_o[g*CNT_W +: CNT_W])
    );
  end

  // Disabled channels do not block release, but with none enabled there is nothing to release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_all_ready <= 1'b0;
    end else begin
      r_all_ready <= (|en_i) && (&(ready_o | ~en_i));
    end
  end

  assign all_ready_o = r_all_ready;

endmodule
